// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_DM = 1'b1
    } port_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, data port and shared-memory signals around mem_arbiter.
// Handshake: a port raises req with stable fields and holds them until its one-cycle valid pulse; stall = req & ~valid.
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
);
    logic              i_if_req;
    logic [31:0]       i_if_addr;
    logic [DATA_W-1:0] o_if_rdata;
    logic              o_if_valid;
    logic              o_if_stall;

    logic              i_dm_req;
    logic              i_dm_we;
    logic [31:0]       i_dm_addr;
    logic [DATA_W-1:0] i_dm_wdata;
    logic [DATA_W-1:0] o_dm_rdata;
    logic              o_dm_valid;
    logic              o_dm_stall;

    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;

    modport slave (
        input  i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_mem_rdata,
        output o_if_rdata, o_if_valid, o_if_stall, o_dm_rdata, o_dm_valid, o_dm_stall,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
    );

    modport master (
        output i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_mem_rdata,
        input  o_if_rdata, o_if_valid, o_if_stall, o_dm_rdata, o_dm_valid, o_dm_stall,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational grant selection between fetch and data ports.
// MEM_ARB_RR_EN selects round-robin on contention; otherwise data port has fixed priority.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic  if_req,
    input  logic  dm_req,
`ifdef MEM_ARB_RR_EN
    input  port_t last_grant,
`endif
    output logic  gnt_valid,
    output port_t gnt
);

    always_comb begin
        gnt_valid = if_req | dm_req;
        gnt       = PORT_DM;
`ifdef MEM_ARB_RR_EN
        // On contention the port that did not win last time goes first.
        if (if_req && dm_req) begin
            gnt = (last_grant == PORT_DM) ? PORT_IF : PORT_DM;
        end else if (if_req) begin
            gnt = PORT_IF;
        end
`else
        if (if_req && !dm_req) begin
            gnt = PORT_IF;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read word memory between fetch and data ports with an IDLE/ISSUE/RESP FSM.
// Build with MEM_ARB_RR_EN for round-robin arbitration instead of fixed data-port priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_p,
    mem_arbiter_if.slave  bus,
    output state_t        dbg_state
);

    state_t            state_q, state_d;
    port_t             grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
    logic              if_valid_q, dm_valid_q;
    logic              take;

    logic  if_elig, dm_elig;
    logic  gnt_valid;
    port_t gnt;

    // A port that is receiving its valid pulse this cycle may not re-arbitrate.
    assign if_elig = bus.i_if_req & ~if_valid_q;
    assign dm_elig = bus.i_dm_req & ~dm_valid_q;

`ifdef MEM_ARB_RR_EN
    port_t last_grant_q;

    always_ff @(posedge i_clk or posedge i_rst_p) begin
        if (i_rst_p) begin
            last_grant_q <= PORT_DM;
        end else if (take) begin
            last_grant_q <= gnt;
        end
    end

    arb_pick u_pick (
        .if_req     (if_elig),
        .dm_req     (dm_elig),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt        (gnt)
    );
`else
    arb_pick u_pick (
        .if_req    (if_elig),
        .dm_req    (dm_elig),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );
`endif

    always_ff @(posedge i_clk or posedge i_rst_p) begin
        if (i_rst_p) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    take    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst_p) begin
        if (i_rst_p) begin
            grant_q    <= PORT_DM;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if (take) begin
                grant_q <= gnt;
                if (gnt == PORT_DM) begin
                    addr_q  <= bus.i_dm_addr[ADDR_W+1:2];
                    we_q    <= bus.i_dm_we;
                    wdata_q <= bus.i_dm_wdata;
                end else begin
                    addr_q <= bus.i_if_addr[ADDR_W+1:2];
                    we_q   <= 1'b0;
                end
            end
            if (state_q == RESP) begin
                if (grant_q == PORT_IF) begin
                    if_rdata_q <= bus.i_mem_rdata;
                    if_valid_q <= 1'b1;
                end else begin
                    dm_valid_q <= 1'b1;
                    // Stores only acknowledge; the last load data stays visible.
                    if (!we_q) begin
                        dm_rdata_q <= bus.i_mem_rdata;
                    end
                end
            end
        end
    end

    // Byte-lane and out-of-range address bits are intentionally dropped (word access, wraps).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.i_if_addr[31:ADDR_W+2], bus.i_if_addr[1:0],
                                bus.i_dm_addr[31:ADDR_W+2], bus.i_dm_addr[1:0]};

    assign bus.o_mem_en    = (state_q == ISSUE);
    assign bus.o_mem_we    = (state_q == ISSUE) & we_q;
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_wdata = wdata_q;

    assign bus.o_if_rdata = if_rdata_q;
    assign bus.o_if_valid = if_valid_q;
    assign bus.o_if_stall = bus.i_if_req & ~if_valid_q;
    assign bus.o_dm_rdata = dm_rdata_q;
    assign bus.o_dm_valid = dm_valid_q;
    assign bus.o_dm_stall = bus.i_dm_req & ~dm_valid_q;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous-read memory and per-port expected-data queues.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic   clk;
    logic   rst;
    state_t dbg_state;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .i_clk     (clk),
        .i_rst_p   (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory model ----------------
    logic [31:0] mem [256];

    always @(posedge clk) begin
        if (bus.o_mem_en) begin
            if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
            bus.i_mem_rdata <= mem[bus.o_mem_addr];
        end
    end

    function automatic logic [31:0] pre(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // ---------------- scoreboard ----------------
    logic [31:0] exp_if_q[$];
    logic [31:0] exp_dm_q[$];
    int          if_hist[$];
    int          dm_hist[$];
    logic [31:0] dm_last;
    int checks;
    int failures;
    int t;
    int if_cnt, dm_cnt, en_cnt;
    bit rr_mode;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        t++;
        if (bus.o_mem_en) en_cnt++;
        if (bus.o_if_valid) begin
            if_cnt++;
            if_hist.push_back(t);
            check("if_exp_pending", 32'(exp_if_q.size() != 0), 32'd1);
            if (exp_if_q.size() != 0) check("if_rdata", bus.o_if_rdata, exp_if_q.pop_front());
        end
        if (bus.o_dm_valid) begin
            dm_cnt++;
            dm_hist.push_back(t);
            check("dm_exp_pending", 32'(exp_dm_q.size() != 0), 32'd1);
            if (exp_dm_q.size() != 0) check("dm_rdata", bus.o_dm_rdata, exp_dm_q.pop_front());
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_if(input logic [31:0] addr, input logic [31:0] exp);
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = addr;
        exp_if_q.push_back(exp);
    endtask

    task automatic drive_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp);
        bus.i_dm_req   = 1'b1;
        bus.i_dm_we    = we;
        bus.i_dm_addr  = addr;
        bus.i_dm_wdata = wdata;
        if (we) begin
            exp_dm_q.push_back(dm_last);
        end else begin
            exp_dm_q.push_back(exp);
            dm_last = exp;
        end
    endtask

    task automatic wait_valid(input bit is_dm, input int budget, input int exp_t, input string tag);
        int c;
        int n;
        c = is_dm ? dm_cnt : if_cnt;
        n = 0;
        while ((is_dm ? dm_cnt : if_cnt) == c && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(t), 32'(exp_t));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int c0, e0;
`ifdef MEM_ARB_RR_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif
        checks = 0; failures = 0; t = 0;
        if_cnt = 0; dm_cnt = 0; en_cnt = 0;
        dm_last = 32'h0;
        rst = 1'b1;
        bus.i_if_req = 1'b0; bus.i_if_addr = '0;
        bus.i_dm_req = 1'b0; bus.i_dm_we = 1'b0; bus.i_dm_addr = '0; bus.i_dm_wdata = '0;
        bus.i_mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] <= pre(i);
        mem[16] <= 32'h0050_0113;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_mem_en", 32'(bus.o_mem_en), 32'd0);
        check("rst_mem_we", 32'(bus.o_mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.o_mem_addr), 32'd0);
        check("rst_if_valid", 32'(bus.o_if_valid), 32'd0);
        check("rst_dm_valid", 32'(bus.o_dm_valid), 32'd0);
        check("rst_if_rdata", bus.o_if_rdata, 32'd0);
        check("rst_dm_rdata", bus.o_dm_rdata, 32'd0);
        rst = 1'b0;
        step(); step();

        // IF-only fetch
        t = 0;
        drive_if(32'h40, 32'h0050_0113);
        #1 check("fetch_stall_c0", 32'(bus.o_if_stall), 32'd1);
        step();
        check("fetch_en_c1", 32'(bus.o_mem_en), 32'd1);
        check("fetch_addr_c1", 32'(bus.o_mem_addr), 32'h10);
        check("fetch_we_c1", 32'(bus.o_mem_we), 32'd0);
        check("fetch_stall_c1", 32'(bus.o_if_stall), 32'd1);
        step();
        check("fetch_en_c2", 32'(bus.o_mem_en), 32'd0);
        check("fetch_stall_c2", 32'(bus.o_if_stall), 32'd1);
        step();
        check("fetch_valid_c3", 32'(bus.o_if_valid), 32'd1);
        check("fetch_stall_c3", 32'(bus.o_if_stall), 32'd0);
        bus.i_if_req = 1'b0;
        step();
        check("fetch_valid_c4", 32'(bus.o_if_valid), 32'd0);

        // DM store then load back
        t = 0;
        drive_dm(1'b1, 32'h84, 32'hDEAD_BEEF, 32'h0);
        step();
        check("st_we", 32'(bus.o_mem_we), 32'd1);
        check("st_addr", 32'(bus.o_mem_addr), 32'h21);
        check("st_wdata", bus.o_mem_wdata, 32'hDEAD_BEEF);
        wait_valid(1'b1, 6, 3, "st_latency");
        bus.i_dm_req = 1'b0;
        step();
        check("st_mem_word", mem[8'h21], 32'hDEAD_BEEF);
        t = 0;
        drive_dm(1'b0, 32'h84, 32'h0, 32'hDEAD_BEEF);
        wait_valid(1'b1, 6, 3, "ld_latency");
        bus.i_dm_req = 1'b0;
        step();

        // Held contention: alternation DM/IF (IF first under round-robin after DM history)
        t = 0;
        if_hist.delete(); dm_hist.delete();
        drive_if(32'h0, pre(0));
        exp_if_q.push_back(pre(0));
        drive_dm(1'b0, 32'h8, 32'h0, pre(2));
        exp_dm_q.push_back(pre(2));
        repeat (12) step();
        bus.i_if_req = 1'b0;
        bus.i_dm_req = 1'b0;
        check("cont_if_count", 32'(if_hist.size()), 32'd2);
        check("cont_dm_count", 32'(dm_hist.size()), 32'd2);
        check("cont_dm_first", 32'(dm_hist[0]), rr_mode ? 32'd6 : 32'd3);
        check("cont_if_first", 32'(if_hist[0]), rr_mode ? 32'd3 : 32'd6);
        check("cont_dm_second", 32'(dm_hist[1]), rr_mode ? 32'd12 : 32'd9);
        check("cont_if_second", 32'(if_hist[1]), rr_mode ? 32'd9 : 32'd12);
        step(); step();

        // Address wrap
        t = 0;
        drive_dm(1'b0, 32'h403, 32'h0, pre(0));
        step();
        check("wrap_en", 32'(bus.o_mem_en), 32'd1);
        check("wrap_addr", 32'(bus.o_mem_addr), 32'h00);
        wait_valid(1'b1, 6, 3, "wrap_latency");
        bus.i_dm_req = 1'b0;
        step(); step();

        // Fresh simultaneous requests after a DM-only grant
        t = 0;
        if_hist.delete(); dm_hist.delete();
        drive_if(32'h40, 32'h0050_0113);
        drive_dm(1'b0, 32'h8, 32'h0, pre(2));
        repeat (7) begin
            step();
            if (bus.o_if_valid) bus.i_if_req = 1'b0;
            if (bus.o_dm_valid) bus.i_dm_req = 1'b0;
        end
        check("pick_dm_t", 32'(dm_hist[0]), rr_mode ? 32'd6 : 32'd3);
        check("pick_if_t", 32'(if_hist[0]), rr_mode ? 32'd3 : 32'd6);
        step();

        // Request held only through its own valid cycle: single access
        t = 0;
        e0 = en_cnt; c0 = if_cnt;
        drive_if(32'h40, 32'h0050_0113);
        wait_valid(1'b0, 6, 3, "held1_latency");
        step();
        bus.i_if_req = 1'b0;
        repeat (4) step();
        check("held1_en_count", 32'(en_cnt - e0), 32'd1);
        check("held1_valid_count", 32'(if_cnt - c0), 32'd1);

        // Request still high one cycle after valid: second access
        t = 0;
        e0 = en_cnt;
        drive_if(32'h40, 32'h0050_0113);
        exp_if_q.push_back(32'h0050_0113);
        wait_valid(1'b0, 6, 3, "held2_first");
        step(); step();
        bus.i_if_req = 1'b0;
        wait_valid(1'b0, 6, 7, "held2_second");
        repeat (3) step();
        check("held2_en_count", 32'(en_cnt - e0), 32'd2);

        // Reset during store ISSUE
        t = 0;
        drive_dm(1'b1, 32'h100, 32'h1234_5678, 32'h0);
        step();
        check("rstst_we_before", 32'(bus.o_mem_we), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rstst_we_async", 32'(bus.o_mem_we), 32'd0);
        check("rstst_en_async", 32'(bus.o_mem_en), 32'd0);
        check("rstst_state_async", 32'(dbg_state), 32'(IDLE));
        exp_dm_q.delete();
        dm_last = 32'h0;
        bus.i_dm_req = 1'b0;
        c0 = dm_cnt;
        step(); step();
        rst = 1'b0;
        step(); step();
        check("rstst_no_valid", 32'(dm_cnt - c0), 32'd0);
        check("rstst_mem_intact", mem[8'h40], pre(64));
        check("rstst_dm_rdata", bus.o_dm_rdata, 32'd0);
        check("rstst_state_idle", 32'(dbg_state), 32'(IDLE));
        t = 0;
        drive_dm(1'b0, 32'h100, 32'h0, pre(64));
        wait_valid(1'b1, 6, 3, "rstst_next_latency");
        bus.i_dm_req = 1'b0;
        step(); step();

        // ---------------- report ----------------
        check("sb_if_drained", 32'(exp_if_q.size()), 32'd0);
        check("sb_dm_drained", 32'(exp_dm_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
